// File: rtl/wave_burst_pkg.sv
// Shared types and defaults for the triangle-wave burst sequencer.
package wave_burst_pkg;

  localparam int unsigned WidthDef    = 5;
  localparam int unsigned CntWDef     = 8;
  localparam int unsigned CmdDepthDef = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRise,
    StFall,
    StDone
  } wbc_state_e;

  typedef struct packed {
    logic [WidthDef-1:0] peak;
    logic [WidthDef-1:0] step;
    logic [CntWDef-1:0]  cycles;
  } wbc_cmd_t;

  function automatic int unsigned cmd_width(input int unsigned width, input int unsigned cnt_w);
    return 2 * width + cnt_w;
  endfunction

endpackage

// File: rtl/wave_cmd_fifo.sv
// Synchronous command FIFO with flush; a full FIFO refuses pushes even when popped that cycle.
module wave_cmd_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AddrW:0]   r_wptr;
  logic [AddrW:0]   r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                     (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + (AddrW+1)'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/wave_burst_ctrl.sv
// Burst sequencer: pops queued commands and drives a saturating triangle ramp on wave.
// Define WBC_FLUSH_ON_ABORT_EN to make abort also empty the command FIFO.
module wave_burst_ctrl
  import wave_burst_pkg::*;
#(
  parameter int unsigned WIDTH     = WidthDef,
  parameter int unsigned CNT_W     = CntWDef,
  parameter int unsigned CMD_DEPTH = CmdDepthDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_peak,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [CNT_W-1:0] cmd_cycles,
  input  logic             abort,
  output logic [WIDTH-1:0] wave,
  output logic             wave_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CmdW = cmd_width(WIDTH, CNT_W);

  wbc_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_wave, w_wave_nxt;
  logic [WIDTH-1:0] r_peak, w_peak_nxt;
  logic [WIDTH-1:0] r_step, w_step_nxt;
  logic [CNT_W-1:0] r_left, w_left_nxt;

  logic             w_push, w_pop, w_flush, w_pop_hold;
  logic             w_full, w_empty;
  logic [CmdW-1:0]  w_wdata, w_rdata;
  logic [WIDTH-1:0] w_q_peak, w_q_step, w_q_step_n;
  logic [CNT_W-1:0] w_q_cycles, w_q_cycles_n;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_rise, w_fall;

`ifdef WBC_FLUSH_ON_ABORT_EN
  assign w_flush    = abort;
  assign w_pop_hold = abort;
  assign cmd_ready  = !rst && !w_full && !abort;
`else
  assign w_flush    = 1'b0;
  assign w_pop_hold = 1'b0;
  assign cmd_ready  = !rst && !w_full;
`endif

  assign w_push  = cmd_valid && cmd_ready;
  assign w_wdata = {cmd_peak, cmd_step, cmd_cycles};

  wave_cmd_fifo #(
    .WIDTH (CmdW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_q_peak, w_q_step, w_q_cycles} = w_rdata;
  assign w_q_step_n   = (w_q_step == '0) ? WIDTH'(1) : w_q_step;
  assign w_q_cycles_n = (w_q_cycles == '0) ? CNT_W'(1) : w_q_cycles;

  // Rise is computed one bit wider so peak+step near the top saturates instead of wrapping.
  assign w_sum  = {1'b0, r_wave} + {1'b0, r_step};
  assign w_rise = (w_sum >= {1'b0, r_peak}) ? r_peak : w_sum[WIDTH-1:0];
  assign w_fall = (r_wave > r_step) ? (r_wave - r_step) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_wave_nxt  = r_wave;
    w_peak_nxt  = r_peak;
    w_step_nxt  = r_step;
    w_left_nxt  = r_left;
    w_pop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_wave_nxt = '0;
        if (!w_empty && !w_pop_hold) begin
          w_pop       = 1'b1;
          w_peak_nxt  = w_q_peak;
          w_step_nxt  = w_q_step_n;
          w_left_nxt  = w_q_cycles_n;
          w_state_nxt = StRise;
        end
      end
      StRise: begin
        w_wave_nxt = w_rise;
        if (w_rise == r_peak) w_state_nxt = StFall;
      end
      StFall: begin
        w_wave_nxt = w_fall;
        if (w_fall == '0) begin
          if (r_left == CNT_W'(1)) begin
            w_state_nxt = StDone;
          end else begin
            w_left_nxt  = r_left - CNT_W'(1);
            w_state_nxt = StRise;
          end
        end
      end
      StDone: begin
        w_wave_nxt  = '0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Abort overrides any transition of an active burst.
    if (abort && (r_state != StIdle)) begin
      w_state_nxt = StIdle;
      w_wave_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_wave  <= '0;
      r_peak  <= '0;
      r_step  <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wave  <= w_wave_nxt;
      r_peak  <= w_peak_nxt;
      r_step  <= w_step_nxt;
      r_left  <= w_left_nxt;
    end
  end

  assign wave       = r_wave;
  assign wave_valid = (r_state == StRise) || (r_state == StFall);
  assign busy       = (r_state != StIdle);
  assign done       = (r_state == StDone);

endmodule
